// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes the SPI_Slave byte stream (command byte, then data/response bytes)
// into register-bus strobes. Define SPI_REG_CTRL_AUTO_INC_EN for burst address auto-increment.
module spi_reg_ctrl #(
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter logic       RD_FLAG     = 1'b1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Recive_Data,
    input  logic       Recive_Data_Valid,
    input  logic       Trans_Start,
    input  logic       Trans_End,
    output logic [7:0] Send_Data,
    output logic       Send_Data_Valid,
    output logic [6:0] Reg_Addr,
    output logic       Reg_Wr_En,
    output logic [7:0] Reg_Wr_Data,
    output logic       Reg_Rd_En,
    input  logic [7:0] Reg_Rd_Data,
    output logic       Busy,
    output logic       Frame_Err
);

`ifdef SPI_REG_CTRL_AUTO_INC_EN
    localparam logic [6:0] ADDR_STEP = 7'd1;
`else
    localparam logic [6:0] ADDR_STEP = 7'd0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_FETCH,
        RD_WAIT,
        RD_DATA
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] addr, addr_nxt;
    logic [7:0] send_data_nxt;
    logic       send_valid_nxt;
    logic [6:0] reg_addr_nxt;
    logic       wr_en_nxt;
    logic [7:0] wr_data_nxt;
    logic       rd_en_nxt;
    logic       frame_err_nxt;

    assign Busy = (state != IDLE);

    // All bus-facing outputs are registered so each strobe lands one cycle after its cause.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            addr            <= '0;
            Send_Data       <= '0;
            Send_Data_Valid <= 1'b0;
            Reg_Addr        <= '0;
            Reg_Wr_En       <= 1'b0;
            Reg_Wr_Data     <= '0;
            Reg_Rd_En       <= 1'b0;
            Frame_Err       <= 1'b0;
        end else begin
            state           <= state_nxt;
            addr            <= addr_nxt;
            Send_Data       <= send_data_nxt;
            Send_Data_Valid <= send_valid_nxt;
            Reg_Addr        <= reg_addr_nxt;
            Reg_Wr_En       <= wr_en_nxt;
            Reg_Wr_Data     <= wr_data_nxt;
            Reg_Rd_En       <= rd_en_nxt;
            Frame_Err       <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        send_data_nxt  = Send_Data;
        send_valid_nxt = 1'b0;
        reg_addr_nxt   = Reg_Addr;
        wr_en_nxt      = 1'b0;
        wr_data_nxt    = Reg_Wr_Data;
        rd_en_nxt      = 1'b0;
        frame_err_nxt  = 1'b0;

        if (Trans_Start) begin
            // A new chip-select frame always restarts cleanly, even mid-frame.
            state_nxt      = CMD;
            send_data_nxt  = STATUS_BYTE;
            send_valid_nxt = 1'b1;
        end else begin
            case (state)
                CMD: begin
                    if (Recive_Data_Valid) begin
                        addr_nxt = Recive_Data[6:0];
                        if (Recive_Data[7] == RD_FLAG) begin
                            state_nxt    = RD_FETCH;
                            rd_en_nxt    = 1'b1;
                            reg_addr_nxt = Recive_Data[6:0];
                        end else begin
                            state_nxt = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (Recive_Data_Valid) begin
                        wr_en_nxt    = 1'b1;
                        reg_addr_nxt = addr;
                        wr_data_nxt  = Recive_Data;
                        addr_nxt     = addr + ADDR_STEP;
                    end
                end
                RD_FETCH: begin
                    state_nxt = RD_WAIT;
                end
                RD_WAIT: begin
                    state_nxt      = RD_DATA;
                    send_data_nxt  = Reg_Rd_Data;
                    send_valid_nxt = 1'b1;
                end
                RD_DATA: begin
                    if (Recive_Data_Valid) begin
                        state_nxt    = RD_FETCH;
                        addr_nxt     = addr + ADDR_STEP;
                        rd_en_nxt    = 1'b1;
                        reg_addr_nxt = addr + ADDR_STEP;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase

            // Frame end: a same-cycle write still goes out, but any read fetch or load is dropped.
            if (Trans_End && state != IDLE) begin
                frame_err_nxt  = (state == CMD) && !Recive_Data_Valid;
                state_nxt      = IDLE;
                rd_en_nxt      = 1'b0;
                send_valid_nxt = 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access command controller that sits behind `SPI_Slave` and turns its byte stream into a parallel register bus. The first byte of every chip-select frame is a command byte: read/write flag plus a 7-bit address. Following bytes are write data or read-response slots, with optional address auto-increment. The controller also drives `Send_Data`/`Send_Data_Valid` back into `SPI_Slave` so that read data is shifted out on MISO.

## Interface
- `STATUS_BYTE`, 8'hA5: byte loaded for transmission at frame start; it is shifted out while the command byte is received.
- `RD_FLAG`, 1: value of command bit 7 that selects a read; the opposite value selects a write.
- `Clk` input 1: system clock, shared with `SPI_Slave`.
- `Rst` input 1: synchronous, active-high reset.
- `Recive_Data` input 8: byte from `SPI_Slave`.
- `Recive_Data_Valid` input 1: one-cycle pulse, `Recive_Data` is valid.
- `Trans_Start` input 1: one-cycle pulse on CS falling edge.
- `Trans_End` input 1: one-cycle pulse on CS rising edge.
- `Send_Data` output 8: next byte for `SPI_Slave` to shift out.
- `Send_Data_Valid` output 1: one-cycle load pulse for `Send_Data`.
- `Reg_Addr` output 7: register address.
- `Reg_Wr_En` output 1: one-cycle write strobe.
- `Reg_Wr_Data` output 8: write data.
- `Reg_Rd_En` output 1: one-cycle read strobe.
- `Reg_Rd_Data` input 8: read data, valid exactly 1 cycle after `Reg_Rd_En`.
- `Busy` output 1: high whenever the state is not IDLE.
- `Frame_Err` output 1: one-cycle pulse when a frame ends before a complete command.

## Operation
- **States:** IDLE, CMD, WR_DATA, RD_FETCH, RD_WAIT, RD_DATA.
- **IDLE:**
  - On `Trans_Start`: load `Send_Data`=`STATUS_BYTE`, pulse `Send_Data_Valid`, go to CMD.
- **CMD:**
  - On `Recive_Data_Valid`: latch `addr`=`Recive_Data[6:0]`.
  - If bit 7 == `RD_FLAG`, go to RD_FETCH; otherwise go to WR_DATA.
- **WR_DATA:**
  - Each `Recive_Data_Valid` produces one write: `Reg_Wr_En`=1, `Reg_Addr`=`addr`, `Reg_Wr_Data`=byte.
  - Then `addr` updates per Configuration. The state stays WR_DATA.
- **RD_FETCH:** `Reg_Rd_En`=1 with `Reg_Addr`=`addr` for one cycle, then RD_WAIT.
- **RD_WAIT:** capture `Reg_Rd_Data` into `Send_Data`, pulse `Send_Data_Valid`, go to RD_DATA.
- **RD_DATA:** on `Recive_Data_Valid`, the master has clocked out one response byte (MOSI content ignored). Update `addr` per Configuration, then go to RD_FETCH.
- **Trans_End in any non-IDLE state:** go to IDLE.
  - `Frame_Err` pulses if the state was CMD, i.e. no command byte was received.
- **Trans_Start in any non-IDLE state:** abort the current frame and behave as the IDLE case (restart in CMD). `Frame_Err` does not pulse.
- **Address arithmetic:** 7-bit modulo. 7'h7F + 1 = 7'h00.

## Timing
- **Reset values:** all outputs 0; state IDLE; `addr`=0.
- **Write latency:** `Recive_Data_Valid` in cycle N → `Reg_Wr_En` in cycle N+1, with `Reg_Addr`/`Reg_Wr_Data` stable in that cycle.
- **Read latency** (command byte or response byte at N):
  - `Reg_Rd_En` at N+1.
  - `Reg_Rd_Data` sampled at N+2.
  - `Send_Data_Valid` with new `Send_Data` at N+3.
- **Start latency:** `Trans_Start` at N → `Send_Data_Valid`/`STATUS_BYTE` at N+1.
- **Strobe widths:** `Reg_Wr_En`, `Reg_Rd_En`, `Send_Data_Valid` and `Frame_Err` are exactly 1 cycle wide. `Send_Data` holds its value until the next load.
- **`Recive_Data_Valid` and `Trans_End` in the same cycle:** the byte is processed first (a pending write is still issued at N+1; a pending read fetch is dropped), then IDLE.
- **`Trans_Start` and `Trans_End` in the same cycle:** `Trans_Start` wins.
- **Reset mid-frame:** the frame is dropped immediately, with no further strobes.
- **Throughput assumption:** the byte period on the SPI side is ≥ 4 `Clk` cycles; the controller never back-pressures.

## Configuration
- Macro: `SPI_REG_CTRL_AUTO_INC_EN`.
- **Defined:** `addr` increments (mod 128) after every write byte and after every read response byte, giving burst access.
- **Undefined:** `addr` is fixed for the whole frame. Every write byte targets the same register, and every read response re-reads the same register.

## Test plan
- **Single write:** frame bytes 8'h05, 8'h3C → one `Reg_Wr_En` with `Reg_Addr`=7'h05, `Reg_Wr_Data`=8'h3C, 1 cycle after the 2nd `Recive_Data_Valid`.
  - `Send_Data` is 8'hA5 at frame start.
- **Burst write with wrap** (AUTO_INC defined): bytes 8'h7F, 8'h11, 8'h22 → writes 7'h7F←8'h11, then 7'h00←8'h22.
  - With the macro undefined: both writes go to 7'h7F.
- **Read:** reg[5]=8'h3C, bytes 8'h85, 8'h00, 8'h00 with reg[6]=8'h4D → `Send_Data` 8'h3C is loaded 3 cycles after the command byte, then 8'h4D.
  - With the macro undefined: 8'h3C twice.
- **Empty frame:** CS low then high with no SCK → exactly one `Frame_Err` pulse, no register strobes, `Busy` back to 0.
- **Edge conditions:**
  - Write data byte and `Trans_End` in the same cycle → the write is still issued.
  - `Trans_Start` during WR_DATA → restart in CMD without `Frame_Err`.
- **Reset:** assert `Rst` mid-burst → all outputs 0 on the next edge. A new frame after reset works normally.
